// File: rtl/dqn_pkg.sv
// Shared definitions for the target_net sequencer.
//   - Layer codes presented on the weight-source and target_net weight buses.
//   - Default node counts and the layer sizes they imply.
//   - FSM state encoding (plain localparams for legacy-tool compatibility).
//   - layer_size(): weight words for a fully connected layer incl. one bias per node.
package dqn_pkg;

  localparam logic [1:0] LayerCodeL1 = 2'b01;
  localparam logic [1:0] LayerCodeL2 = 2'b10;
  localparam logic [1:0] LayerCodeL3 = 2'b11;

  localparam int unsigned DefInputNodes  = 2;
  localparam int unsigned DefHidden1     = 32;
  localparam int unsigned DefHidden2     = 32;
  localparam int unsigned DefOutputNodes = 3;

  // Each node owns fan_in weights followed by its bias word.
  function automatic int unsigned layer_size(input int unsigned nodes,
                                             input int unsigned fan_in);
    return nodes * (fan_in + 1);
  endfunction

  localparam int unsigned DefLayer1Size = DefHidden1 * (DefInputNodes + 1);
  localparam int unsigned DefLayer2Size = DefHidden2 * (DefHidden1 + 1);
  localparam int unsigned DefLayer3Size = DefOutputNodes * (DefHidden2 + 1);

  localparam int unsigned StateWidth = 3;

  localparam logic [StateWidth-1:0] StIdle     = 3'd0;
  localparam logic [StateWidth-1:0] StRdL1     = 3'd1;
  localparam logic [StateWidth-1:0] StRdL2     = 3'd2;
  localparam logic [StateWidth-1:0] StRdL3     = 3'd3;
  localparam logic [StateWidth-1:0] StWDone    = 3'd4;
  localparam logic [StateWidth-1:0] StLoadData = 3'd5;
  localparam logic [StateWidth-1:0] StWaitQ    = 3'd6;
  localparam logic [StateWidth-1:0] StResult   = 3'd7;

endpackage

// File: rtl/layer_addr_gen.sv
// Per-layer weight read address generator.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   start_i          begin a new layer at address 0 on the next cycle
//   size_i           number of words in the current layer
//   layer_i          layer code to carry alongside each read
//   rd_en_o/addr_o   weight-source read strobe and address
//   last_o           high on the cycle the final address of the layer is issued
//   wvalid_o/wlayer_o/waddr_o  read qualifiers delayed one cycle to line up with read data
module layer_addr_gen #(
  parameter int unsigned AddrWidth  = 11,
  parameter int unsigned LayerWidth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AddrWidth-1:0]  size_i,
  input  logic [LayerWidth-1:0] layer_i,
  output logic                  rd_en_o,
  output logic [AddrWidth-1:0]  addr_o,
  output logic                  last_o,
  output logic                  wvalid_o,
  output logic [LayerWidth-1:0] wlayer_o,
  output logic [AddrWidth-1:0]  waddr_o
);

  logic                  active_q, active_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  wvalid_q, wvalid_d;
  logic [LayerWidth-1:0] wlayer_q, wlayer_d;
  logic [AddrWidth-1:0]  waddr_q, waddr_d;
  logic [AddrWidth-1:0]  last_addr;

  assign last_addr = size_i - AddrWidth'(1);
  assign last_o    = active_q && (addr_q == last_addr);

  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    if (start_i) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
        addr_d   = '0;
      end else begin
        addr_d = addr_q + AddrWidth'(1);
      end
    end
  end

  // Read data returns one cycle after the strobe, so the qualifiers trail by one.
  always_comb begin
    wvalid_d = active_q;
    wlayer_d = active_q ? layer_i : '0;
    waddr_d  = active_q ? addr_q : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      wvalid_q <= 1'b0;
      wlayer_q <= '0;
      waddr_q  <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      wvalid_q <= wvalid_d;
      wlayer_q <= wlayer_d;
      waddr_q  <= waddr_d;
    end
  end

  assign rd_en_o  = active_q;
  assign addr_o   = addr_q;
  assign wvalid_o = wvalid_q;
  assign wlayer_o = wlayer_q;
  assign waddr_o  = waddr_q;

endmodule

// File: rtl/target_net_ctrl.sv
// Sequencer for the target_net inference core.
//   clk, rst                       clock, asynchronous active-high reset
//   i_update_request               reload all weights (sticky if the FSM is busy)
//   i_infer_valid/o_infer_ready    inference request handshake
//   i_state                        state vector, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_wsrc_*/i_wsrc_data           weight-source memory read port (1-cycle read latency)
//   o_weight_*                     weight stream into target_net
//   o_load_weight_done             one-cycle pulse after the last weight
//   o_data_*                       state vector stream into target_net
//   i_q_max_valid/i_q_max          result from target_net
//   o_q_max_valid/o_q_max          result to requester
//   o_busy, o_weights_loaded       status
module target_net_ctrl
  import dqn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                    = 32,
  parameter int unsigned LAYER_WIDTH                   = 2,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11,
  parameter int unsigned DATA_COUNTER_WIDTH            = 5
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_update_request,
  input  logic                                       i_infer_valid,
  output logic                                       o_infer_ready,
  input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_state,
  output logic                                       o_wsrc_rd_en,
  output logic [LAYER_WIDTH-1:0]                     o_wsrc_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_wsrc_addr,
  input  logic [DATA_WIDTH-1:0]                      i_wsrc_data,
  output logic                                       o_weight_valid,
  output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_weight_addr,
  output logic [DATA_WIDTH-1:0]                      o_weight,
  output logic                                       o_load_weight_done,
  output logic                                       o_data_valid,
  output logic [DATA_COUNTER_WIDTH-1:0]              o_data_addr,
  output logic [DATA_WIDTH-1:0]                      o_data,
  input  logic                                       i_q_max_valid,
  input  logic [DATA_WIDTH-1:0]                      i_q_max,
  output logic                                       o_q_max_valid,
  output logic [DATA_WIDTH-1:0]                      o_q_max,
  output logic                                       o_busy,
  output logic                                       o_weights_loaded
);

  localparam int unsigned L1Size =
      layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE);
  localparam int unsigned L2Size =
      layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1);
  localparam int unsigned L3Size =
      layer_size(NUMBER_OF_OUTPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_2);
  localparam int unsigned StateBits = NUMBER_OF_INPUT_NODE * DATA_WIDTH;

  logic [StateWidth-1:0]           state_q, state_d;
  logic                            pending_q, pending_d;
  logic                            loaded_q, loaded_d;
  logic                            done_q, done_d;
  logic [StateBits-1:0]            vec_q, vec_d;
  logic [DATA_COUNTER_WIDTH-1:0]   data_cnt_q, data_cnt_d;
  logic [DATA_WIDTH-1:0]           q_max_q, q_max_d;

  logic                            gen_start;
  logic [WEIGHT_COUNTER_WIDTH-1:0] gen_size;
  logic [LAYER_WIDTH-1:0]          gen_layer;
  logic                            gen_rd_en;
  logic                            gen_last;
  logic                            update_go;
  logic                            infer_accept;
  logic [DATA_WIDTH-1:0]           data_word;

  // Layer code and size follow the current read state.
  always_comb begin
    gen_layer = '0;
    gen_size  = '0;
    unique case (state_q)
      StRdL1: begin
        gen_layer = LAYER_WIDTH'(LayerCodeL1);
        gen_size  = WEIGHT_COUNTER_WIDTH'(L1Size);
      end
      StRdL2: begin
        gen_layer = LAYER_WIDTH'(LayerCodeL2);
        gen_size  = WEIGHT_COUNTER_WIDTH'(L2Size);
      end
      StRdL3: begin
        gen_layer = LAYER_WIDTH'(LayerCodeL3);
        gen_size  = WEIGHT_COUNTER_WIDTH'(L3Size);
      end
      default: ;
    endcase
  end

  assign update_go     = (state_q == StIdle) && (pending_q || i_update_request);
  assign o_infer_ready = (state_q == StIdle) && loaded_q && !pending_q;
  assign infer_accept  = o_infer_ready && i_infer_valid && !i_update_request;

  // L1 starts straight out of IDLE; L2/L3 spend their first cycle restarting the
  // counter, which is the single idle cycle between layers on the weight stream.
  assign gen_start = update_go ||
                     (((state_q == StRdL2) || (state_q == StRdL3)) && !gen_rd_en);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    vec_d      = vec_q;
    data_cnt_d = data_cnt_q;
    q_max_d    = q_max_q;

    if ((state_q != StIdle) && i_update_request) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (update_go) begin
          state_d   = StRdL1;
          pending_d = 1'b0;
          loaded_d  = 1'b0;
        end else if (infer_accept) begin
          state_d    = StLoadData;
          vec_d      = i_state;
          data_cnt_d = '0;
        end
      end
      StRdL1: if (gen_last) state_d = StRdL2;
      StRdL2: if (gen_last) state_d = StRdL3;
      StRdL3: if (gen_last) state_d = StWDone;
      StWDone: begin
        // Registered pulse lands one cycle after the last weight leaves the pipeline.
        done_d   = 1'b1;
        loaded_d = 1'b1;
        state_d  = StIdle;
      end
      StLoadData: begin
        if (data_cnt_q == DATA_COUNTER_WIDTH'(NUMBER_OF_INPUT_NODE - 1)) begin
          data_cnt_d = '0;
          state_d    = StWaitQ;
        end else begin
          data_cnt_d = data_cnt_q + DATA_COUNTER_WIDTH'(1);
        end
      end
      StWaitQ: begin
        if (i_q_max_valid) begin
          q_max_d = i_q_max;
          state_d = StResult;
        end
      end
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      vec_q      <= '0;
      data_cnt_q <= '0;
      q_max_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
      vec_q      <= vec_d;
      data_cnt_q <= data_cnt_d;
      q_max_q    <= q_max_d;
    end
  end

  layer_addr_gen #(
    .AddrWidth  (WEIGHT_COUNTER_WIDTH),
    .LayerWidth (LAYER_WIDTH)
  ) u_addr_gen (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (gen_start),
    .size_i   (gen_size),
    .layer_i  (gen_layer),
    .rd_en_o  (gen_rd_en),
    .addr_o   (o_wsrc_addr),
    .last_o   (gen_last),
    .wvalid_o (o_weight_valid),
    .wlayer_o (o_weight_layer),
    .waddr_o  (o_weight_addr)
  );

  assign o_wsrc_rd_en = gen_rd_en;
  assign o_wsrc_layer = gen_rd_en ? gen_layer : '0;
  assign o_weight     = o_weight_valid ? i_wsrc_data : '0;

  always_comb begin
    data_word = '0;
    for (int k = 0; k < int'(NUMBER_OF_INPUT_NODE); k++) begin
      if (data_cnt_q == DATA_COUNTER_WIDTH'(k)) begin
        data_word = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_data_valid       = (state_q == StLoadData);
  assign o_data_addr        = o_data_valid ? data_cnt_q : '0;
  assign o_data             = o_data_valid ? data_word : '0;
  assign o_q_max_valid      = (state_q == StResult);
  assign o_q_max            = o_q_max_valid ? q_max_q : '0;
  assign o_load_weight_done = done_q;
  assign o_weights_loaded   = loaded_q;
  assign o_busy             = (state_q != StIdle);

endmodule
